// File: rtl/video_types.sv
// video_types: shared LCD raster constants, mode encoding and register views.
package video_types;
    localparam int DOTS_PER_LINE   = 456;
    localparam int LINES_PER_FRAME = 154;
    localparam int OAM_DOTS        = 80;
    localparam int XFER_DOTS       = 172;
    localparam int VBLANK_LINE     = 144;

    typedef enum logic [1:0] {
        HBLANK  = 2'd0,
        VBLANK  = 2'd1,
        OAMSCAN = 2'd2,
        XFER    = 2'd3
    } LcdMode;

    typedef struct packed {
        logic lcd_enable;
        logic win_map;
        logic win_en;
        logic tile_sel;
        logic bg_map;
        logic obj_size;
        logic obj_en;
        logic bg_en;
    } lcdc_bits_t;

    typedef union packed {
        logic [7:0] raw;
        lcdc_bits_t f;
    } LcdControl;

    typedef struct packed {
        logic       reserved;
        logic       lyc_ie;
        logic       oam_ie;
        logic       vblank_ie;
        logic       hblank_ie;
        logic       lyc_flag;
        logic [1:0] mode;
    } stat_bits_t;

    typedef union packed {
        logic [7:0] raw;
        stat_bits_t f;
    } LcdStatus;
endpackage

// File: rtl/lcd_dot_counter.sv
// lcd_dot_counter: dot-within-line and line-within-frame position counters.
module lcd_dot_counter #(
    parameter int DOTS_PER_LINE   = 456,
    parameter int LINES_PER_FRAME = 154
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot_en,
    input  logic       enable,
    output logic [7:0] ly,
    output logic [8:0] dot_x,
    output logic       wrap
);
    logic [7:0] r_ly;
    logic [8:0] r_dot_x;
    logic       w_last_line;

    assign wrap        = enable && dot_en && r_dot_x == 9'(DOTS_PER_LINE - 1);
    assign w_last_line = r_ly == 8'(LINES_PER_FRAME - 1);
    assign ly          = r_ly;
    assign dot_x       = r_dot_x;

    // disable has priority over a coincident dot tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ly    <= '0;
            r_dot_x <= '0;
        end else if (!enable) begin
            r_ly    <= '0;
            r_dot_x <= '0;
        end else if (dot_en) begin
            r_dot_x <= wrap ? '0 : r_dot_x + 9'd1;
            if (wrap)
                r_ly <= w_last_line ? '0 : r_ly + 8'd1;
        end
    end
endmodule

// File: rtl/lcd_timing_scheduler.sv
// lcd_timing_scheduler: LCD raster timing, mode decode, VRAM/OAM access and interrupts.
// STAT interrupt logic is built only when LCD_STAT_IRQ_EN is defined.
module lcd_timing_scheduler import video_types::*; #(
    parameter int DOTS_PER_LINE   = video_types::DOTS_PER_LINE,
    parameter int LINES_PER_FRAME = video_types::LINES_PER_FRAME,
    parameter int OAM_DOTS        = video_types::OAM_DOTS,
    parameter int XFER_DOTS       = video_types::XFER_DOTS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dot_en,
    input  LcdControl  lcdc,
    input  LcdStatus   stat_cfg,
    input  logic [7:0] lyc,
    output logic [7:0] ly,
    output logic [8:0] dot_x,
    output logic [1:0] mode,
    output logic       coincidence,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       line_start,
    output logic       cpu_vram_ok,
    output logic       cpu_oam_ok
);
    logic   w_en, w_wrap, w_unused;
    LcdMode w_mode;
    logic   r_en_d, r_line_start, r_vblank_irq;

    assign w_en = lcdc.f.lcd_enable;

    lcd_dot_counter #(
        .DOTS_PER_LINE  (DOTS_PER_LINE),
        .LINES_PER_FRAME(LINES_PER_FRAME)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .dot_en(dot_en),
        .enable(w_en),
        .ly    (ly),
        .dot_x (dot_x),
        .wrap  (w_wrap)
    );

    assign w_mode = !w_en                                ? HBLANK  :
                    ly >= 8'(VBLANK_LINE)                ? VBLANK  :
                    dot_x < 9'(OAM_DOTS)                 ? OAMSCAN :
                    dot_x < 9'(OAM_DOTS + XFER_DOTS)     ? XFER    : HBLANK;

    assign mode        = w_mode;
    assign coincidence = ly == lyc;
    assign cpu_vram_ok = w_mode != XFER;
    assign cpu_oam_ok  = w_mode != OAMSCAN && w_mode != XFER;
    assign line_start  = r_line_start;
    assign vblank_irq  = r_vblank_irq;

    // r_en_d resets high so leaving reset with the LCD on is not seen as a re-enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en_d       <= 1'b1;
            r_line_start <= 1'b0;
            r_vblank_irq <= 1'b0;
        end else begin
            r_en_d       <= w_en;
            r_line_start <= w_wrap || (w_en && !r_en_d);
            r_vblank_irq <= w_wrap && ly == 8'(VBLANK_LINE - 1);
        end
    end

`ifdef LCD_STAT_IRQ_EN
    logic w_stat_line, r_stat_line, r_stat_irq;

    assign w_stat_line = (stat_cfg.f.lyc_ie    && coincidence)      ||
                         (stat_cfg.f.oam_ie    && w_mode == OAMSCAN) ||
                         (stat_cfg.f.vblank_ie && w_mode == VBLANK)  ||
                         (stat_cfg.f.hblank_ie && w_mode == HBLANK);
    assign stat_irq = r_stat_irq;
    assign w_unused = ^{lcdc.raw[6:0], stat_cfg.raw[7], stat_cfg.raw[2:0]};

    // edge detect on the registered line gives STAT its blocking behaviour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_line <= 1'b0;
            r_stat_irq  <= 1'b0;
        end else begin
            r_stat_line <= w_en && w_stat_line;
            r_stat_irq  <= w_en && w_stat_line && !r_stat_line;
        end
    end
`else
    assign stat_irq = 1'b0;
    assign w_unused = ^{lcdc.raw[6:0], stat_cfg.raw};
`endif
endmodule

// File: tb/tb_lcd_timing_scheduler.sv
// tb_lcd_timing_scheduler: directed raster, mode, access and interrupt checks.
module tb_lcd_timing_scheduler;
`ifdef LCD_STAT_IRQ_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif
    logic       clk = 1'b0, rst_n = 1'b0, dot_en = 1'b0;
    logic [7:0] lcdc = 8'h80, stat_cfg = 8'h00, lyc = 8'hFF;
    logic [7:0] ly;
    logic [8:0] dot_x;
    logic [1:0] mode;
    logic       coincidence, vblank_irq, stat_irq, line_start, cpu_vram_ok, cpu_oam_ok;
    int         checks = 0, errors = 0;
    int         w_vb = 0, w_ls = 0, w_si = 0, fr_vb = 0, fr_ls = 0;

    always #5 clk = ~clk;

    lcd_timing_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dot_en     (dot_en),
        .lcdc       (lcdc),
        .stat_cfg   (stat_cfg),
        .lyc        (lyc),
        .ly         (ly),
        .dot_x      (dot_x),
        .mode       (mode),
        .coincidence(coincidence),
        .vblank_irq (vblank_irq),
        .stat_irq   (stat_irq),
        .line_start (line_start),
        .cpu_vram_ok(cpu_vram_ok),
        .cpu_oam_ok (cpu_oam_ok)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            if (vblank_irq) begin w_vb++; fr_vb++; end
            if (line_start) begin w_ls++; fr_ls++; end
            if (stat_irq) w_si++;
        end
    endtask

    task automatic clr();
        w_vb = 0;
        w_ls = 0;
        w_si = 0;
    endtask

    task automatic chk_pos(input string tag, input int l, input int d);
        chk({tag, "_ly"}, 32'(ly), 32'(l));
        chk({tag, "_dot"}, 32'(dot_x), 32'(d));
    endtask

    task automatic chk_mode(input string tag, input int m, input bit v, input bit o);
        chk({tag, "_mode"}, 32'(mode), 32'(m));
        chk({tag, "_vram"}, 32'(cpu_vram_ok), 32'(v));
        chk({tag, "_oam"}, 32'(cpu_oam_ok), 32'(o));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_pos("rst", 0, 0);
        chk_mode("rst", 2, 1'b1, 1'b0);
        chk("rst_vblank", 32'(vblank_irq), 0);
        chk("rst_stat", 32'(stat_irq), 0);
        chk("rst_line_start", 32'(line_start), 0);
        rst_n  = 1'b1;
        dot_en = 1'b1;
        run(1);
        chk_pos("first_dot", 0, 1);
        chk("first_line_start", 32'(line_start), 0);
        // LYC at line 3, then the HBlank term overlaps it
        stat_cfg = 8'h40;
        lyc      = 8'd3;
        clr();
        run(1367);
        chk_pos("blk_arrive", 3, 0);
        chk("blk_pre_pulses", 32'(w_si), 0);
        chk("blk_coinc", 32'(coincidence), 1);
        run(1);
        chk("blk_first_pulse", 32'(stat_irq), 32'(STAT));
        stat_cfg = 8'h48;
        clr();
        run(454);
        chk("blk_overlap_pulses", 32'(w_si), 0);
        chk_pos("blk_end", 3, 455);
        stat_cfg = 8'h00;
        // mode boundaries on line 5
        run(536);
        chk_pos("mb79", 5, 79);
        chk_mode("mb79", 2, 1'b1, 1'b0);
        run(1);
        chk_mode("mb80", 3, 1'b0, 1'b0);
        run(171);
        chk_pos("mb251", 5, 251);
        chk_mode("mb251", 3, 1'b0, 1'b0);
        run(1);
        chk_mode("mb252", 0, 1'b1, 1'b1);
        // LYC interrupt at line 10 and lyc rewrites
        stat_cfg = 8'h40;
        lyc      = 8'd10;
        clr();
        run(2028);
        chk_pos("lyc_arrive", 10, 0);
        chk("lyc_pre_pulses", 32'(w_si), 0);
        run(1);
        chk("lyc_pulse", 32'(stat_irq), 32'(STAT));
        run(9);
        lyc = 8'd10;
        clr();
        run(10);
        chk("lyc_rewrite_pulses", 32'(w_si), 0);
        clr();
        lyc = 8'd11;
        #1 chk("lyc11_coinc", 32'(coincidence), 0);
        run(2);
        lyc = 8'd10;
        #1 chk("lyc10_coinc", 32'(coincidence), 1);
        run(3);
        chk("lyc_toggle_pulses", 32'(w_si), 32'(STAT));
        stat_cfg = 8'h00;
        lyc      = 8'hFF;
        // remainder of the full frame
        run(61078);
        chk_pos("pre_vblank", 143, 455);
        chk("pre_vblank_cnt", 32'(fr_vb), 0);
        run(1);
        chk("vblank_pulse", 32'(vblank_irq), 1);
        chk_mode("vblank", 1, 1'b1, 1'b1);
        run(4560);
        chk_pos("frame_end", 0, 0);
        chk("frame_vblank_cnt", 32'(fr_vb), 1);
        chk("frame_line_starts", 32'(fr_ls), 154);
        // disable mid-frame with a coincident dot tick
        run(1112);
        chk_pos("pre_dis", 2, 200);
        lcdc     = 8'h00;
        stat_cfg = 8'h78;
        lyc      = 8'd0;
        clr();
        run(1);
        chk_pos("dis", 0, 0);
        chk_mode("dis", 0, 1'b1, 1'b1);
        run(5);
        chk("dis_coinc", 32'(coincidence), 1);
        chk("dis_irqs", 32'(w_vb + w_ls + w_si), 0);
        stat_cfg = 8'h00;
        lyc      = 8'hFF;
        lcdc     = 8'h80;
        dot_en   = 1'b0;
        #1 chk("reen_mode_now", 32'(mode), 2);
        run(1);
        chk("reen_line_start", 32'(line_start), 1);
        chk_pos("reen", 0, 0);
        chk("reen_mode", 32'(mode), 2);
        run(1);
        chk("reen_line_start_drop", 32'(line_start), 0);
        dot_en = 1'b1;
        // asynchronous reset between edges while a pulse is live
        run(456);
        chk_pos("pre_rst", 1, 0);
        chk("pre_rst_line_start", 32'(line_start), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_line_start", 32'(line_start), 0);
        chk_pos("arst", 0, 0);
        chk("arst_mode", 32'(mode), 2);
        clr();
        run(2);
        chk("arst_irqs", 32'(w_vb + w_ls + w_si), 0);
        rst_n = 1'b1;
        run(1);
        chk_pos("post_rst", 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
